// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - MM:SS BCD countdown game timer with start/pause/load/bonus control
module game_timer_bcd #(
  parameter int TICK_DIV  = 50000000,
  parameter int BONUS_SEC = 5
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iLOAD,
  input  logic [7:0]  iLOAD_MIN,
  input  logic [7:0]  iLOAD_SEC,
  input  logic        iSTART,
  input  logic        iPAUSE,
  input  logic        iBONUS,
  output logic [15:0] oDIG,
  output logic        oRUNNING,
  output logic        oEXPIRED,
  output logic        oTIME_UP
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] BONUS = 4'(BONUS_SEC);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_EXP   = 2'd3;

  logic [1:0]    state, state_nx;
  logic [15:0]   dig_q, dig_nx, dig_work, load_dig;
  logic [PW-1:0] presc, presc_nx;
  logic          time_up_q, time_up_nx;
  logic          tick;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // One-second BCD decrement with borrow; 00:00 stays put.
  function automatic logic [15:0] bcd_dec(input logic [15:0] t);
    logic [3:0] a, b, c, d;
    {a, b, c, d} = t;
    if (t != 16'h0000) begin
      if (d != 4'd0) d = d - 4'd1;
      else begin
        d = 4'd9;
        if (c != 4'd0) c = c - 4'd1;
        else begin
          c = 4'd5;
          if (b != 4'd0) b = b - 4'd1;
          else begin
            b = 4'd9;
            a = a - 4'd1;
          end
        end
      end
    end
    return {a, b, c, d};
  endfunction

  // BCD add of a single-digit second count, saturating at 99:59.
  function automatic logic [15:0] bcd_add_sat(input logic [15:0] t, input logic [3:0] n);
    logic [3:0] a, b, c, d;
    logic [4:0] s;
    logic       cy;
    logic [15:0] r;
    {a, b, c, d} = t;
    s = {1'b0, d} + {1'b0, n};
    if (s > 5'd9) begin d = 4'(s - 5'd10); cy = 1'b1; end
    else begin d = s[3:0]; cy = 1'b0; end
    s = {1'b0, c} + {4'b0000, cy};
    if (s > 5'd5) begin c = 4'd0; cy = 1'b1; end
    else begin c = s[3:0]; cy = 1'b0; end
    s = {1'b0, b} + {4'b0000, cy};
    if (s > 5'd9) begin b = 4'd0; cy = 1'b1; end
    else begin b = s[3:0]; cy = 1'b0; end
    s = {1'b0, a} + {4'b0000, cy};
    if (s > 5'd9) r = 16'h9959;
    else r = {s[3:0], b, c, d};
    return r;
  endfunction

  assign tick = (state == S_RUN) && (presc == PRESC_MAX);
  assign load_dig = {clamp_digit(iLOAD_MIN[7:4], 4'd9), clamp_digit(iLOAD_MIN[3:0], 4'd9),
                     clamp_digit(iLOAD_SEC[7:4], 4'd5), clamp_digit(iLOAD_SEC[3:0], 4'd9)};

  // Next-state logic: strict pulse priority load > start > pause > bonus, tick folded in.
  always_comb begin
    state_nx   = state;
    presc_nx   = presc;
    dig_work   = dig_q;
    dig_nx     = dig_q;
    time_up_nx = 1'b0;
    if (iLOAD) begin
      dig_nx   = load_dig;
      state_nx = S_IDLE;
      presc_nx = '0;
    end else begin
      if (state == S_RUN) presc_nx = tick ? '0 : presc + 1'b1;
      if (tick) dig_work = bcd_dec(dig_q);
      if (iSTART) begin
        if (state == S_IDLE && dig_q != 16'h0000) begin
          state_nx = S_RUN;
          presc_nx = '0;
        end
      end else if (iPAUSE) begin
        if (state == S_RUN) state_nx = S_PAUSE;
        else if (state == S_PAUSE) state_nx = S_RUN;
      end else if (iBONUS && (state == S_RUN || state == S_PAUSE)) begin
        dig_work = bcd_add_sat(dig_work, BONUS);
      end
      dig_nx = dig_work;
      if (tick && dig_work == 16'h0000) begin
        state_nx   = S_EXP;
        time_up_nx = 1'b1;
      end
    end
  end

  // State, time digits, prescaler and time-up pulse registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state     <= S_IDLE;
      dig_q     <= 16'h0000;
      presc     <= '0;
      time_up_q <= 1'b0;
    end else begin
      state     <= state_nx;
      dig_q     <= dig_nx;
      presc     <= presc_nx;
      time_up_q <= time_up_nx;
    end
  end

  assign oDIG     = dig_q;
  assign oRUNNING = (state == S_RUN);
  assign oEXPIRED = (state == S_EXP);
  assign oTIME_UP = time_up_q;

endmodule

// File: doc/game_timer_bcd.md
Name: game_timer_bcd

Overview:
- Countdown game timer, MM:SS, kept entirely in BCD.
- Sits directly upstream of the 7-segment decoders: each of its four 4-bit BCD digit outputs drives one decoder/HEX display.
- Adds start/pause/load control, a time-bonus input and a time-up indication for the game FSM.

Parameters:
- TICK_DIV, 50000000, clock cycles per one-second tick (50 MHz board clock); benches use small values.
- BONUS_SEC, 5, seconds added per iBONUS pulse; legal range 1..9.

Ports:
- iCLK  in  1  system clock, all logic rising-edge.
- iRST_N  in  1  asynchronous active-low reset.
- iLOAD  in  1  one-cycle pulse: load iLOAD_MIN/iLOAD_SEC, go IDLE.
- iLOAD_MIN  in  8  BCD minutes {tens,ones}.
- iLOAD_SEC  in  8  BCD seconds {tens,ones}.
- iSTART  in  1  one-cycle pulse: begin counting.
- iPAUSE  in  1  one-cycle pulse: toggle RUN/PAUSE.
- iBONUS  in  1  one-cycle pulse: add BONUS_SEC seconds.
- oDIG  out  16  {min tens, min ones, sec tens, sec ones}, each 4-bit BCD.
- oRUNNING  out  1  high in RUN.
- oEXPIRED  out  1  high in EXPIRED.
- oTIME_UP  out  1  one-cycle pulse on reaching 00:00.

Behaviour:
- Reset (async, iRST_N low):
  - state IDLE, time 00:00, oDIG=16'h0000.
  - oRUNNING=0, oEXPIRED=0, oTIME_UP=0, prescaler=0.
  - Release is synchronous to iCLK.
- State machine, states IDLE, RUN, PAUSE, EXPIRED:
  - IDLE -> RUN: iSTART while time != 00:00. iSTART at 00:00 is ignored.
  - RUN <-> PAUSE: iPAUSE. iPAUSE in IDLE or EXPIRED is ignored.
  - RUN -> EXPIRED: a tick decrements time to 00:00.
  - Any state -> IDLE: iLOAD.
  - EXPIRED is left only via iLOAD or reset.
- Control priority, same cycle: iLOAD > iSTART > iPAUSE > iBONUS. A lower-priority pulse that loses is dropped, not queued.
- Load:
  - Digits are registered one cycle after iLOAD.
  - Out-of-range digits clamp: any ones digit >9 becomes 9; seconds tens >5 becomes 5; minutes tens >9 becomes 9.
  - Prescaler clears.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; holds its value in PAUSE.
  - Clears on load and on IDLE->RUN.
  - The tick is the cycle in which the prescaler equals TICK_DIV-1 in RUN; the prescaler wraps to 0 that cycle.
- Decrement, on tick, one second with BCD borrow:
  - Seconds ones 0 -> 9 with borrow; seconds tens 0 -> 5 with borrow.
  - Minutes ones 0 -> 9 with borrow; minutes tens decrements.
  - 00:00 is never decremented.
- Bonus:
  - Accepted in RUN and PAUSE only; ignored in IDLE and EXPIRED.
  - Adds BONUS_SEC with BCD carry: seconds 59 -> 00 carries into minutes.
  - Result saturates at 99:59.
- Bonus coinciding with a tick: result = time − 1 + BONUS_SEC, saturated at 99:59. If time was 00:01, no expiry occurs.
- Latency:
  - oDIG, oRUNNING and oEXPIRED are registered and change one cycle after the causing event (pulse or tick edge).
  - oTIME_UP is high for exactly the one cycle in which oEXPIRED first goes high.
- Reset mid-operation: immediate return to reset values, with no oTIME_UP pulse.
- oDIG always holds valid BCD: every nibble ≤9 and seconds tens ≤5.

Test Plan:
1. Reset, iLOAD with MIN=8'h01, SEC=8'h02, iSTART, TICK_DIV=4 -> oDIG sequence 0102, 0101, 0100, 0059, ..., 0000, one change every 4 cycles. oTIME_UP pulses once at 0000, oEXPIRED stays high, oRUNNING=0.
2. Load 00:10, start, iPAUSE after 2 ticks (oDIG=0008), wait 20 cycles, iPAUSE -> oDIG holds 0008 while paused. The next tick arrives (TICK_DIV − elapsed prescaler count) cycles after resume.
3. Load 99:57 in RUN, iBONUS -> saturates at 9959. Load 00:58, iBONUS -> 0103.
4. Load 00:01, start, iBONUS on the tick cycle -> oDIG=0005, no oTIME_UP, stays in RUN.
5. Load MIN=8'hAF, SEC=8'h7C -> oDIG=9959. iSTART with time 0000 -> stays IDLE, oRUNNING=0.
6. Assert iRST_N low mid-RUN at 0045 -> oDIG=0000 and all flags 0 asynchronously. Simultaneous iLOAD+iSTART -> load wins, state IDLE.
